serdesphy_rx_deframer: RTL and testbench



---
 rtl/serdesphy_pcs_pkg.sv | 33 +++
 rtl/serdesphy_frame_check.sv | 40 ++++
 rtl/serdesphy_rx_deframer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_serdesphy_rx_deframer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pcs_pkg.sv
// ---------------------------------------------------------------------------
// serdesphy_pcs_pkg
//
// Constants and types shared by the PCS framing blocks (the TX framer and
// the RX deframer). A frame is 10 bits wide, and its first serial bit is bit 9:
//   [9:8] header  (HDR_DATA or HDR_IDLE)
//   [7:4] nibble N
//   [3:0] ~N      (check nibble)
// An idle frame always carries N = IDLE_NIBBLE.
//
// No ports (package).
// ---------------------------------------------------------------------------
package serdesphy_pcs_pkg;

    localparam int          FRAME_W     = 10;
    localparam logic [1:0]  HDR_DATA    = 2'b10;
    localparam logic [1:0]  HDR_IDLE    = 2'b01;
    localparam logic [3:0]  IDLE_NIBBLE = 4'h5;

    // Alignment state; the encoding is visible on the rx_state port.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    // Assembles a complete frame from a header and a payload nibble.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] hdr,
                                                       input logic [3:0] nibble);
        return {hdr, nibble, ~nibble};
    endfunction

endpackage

// File: rtl/serdesphy_frame_check.sv
// ---------------------------------------------------------------------------
// serdesphy_frame_check
//
// Purely combinational check of one 10-bit candidate window.
//
// Ports:
//   window   in  FRAME_W  candidate frame, bit 9 = first received bit
//   good     out 1        legal header, check nibble matches, and an idle
//                         frame carries IDLE_NIBBLE
//   is_data  out 1        header is HDR_DATA
//   is_idle  out 1        header is HDR_IDLE and the nibble is IDLE_NIBBLE
//   nibble   out 4        payload nibble N
//
// Deserializer errors are not visible here; the deframer folds them in.
// ---------------------------------------------------------------------------
module serdesphy_frame_check
    import serdesphy_pcs_pkg::*;
(
    input  logic [FRAME_W-1:0] window,
    output logic               good,
    output logic               is_data,
    output logic               is_idle,
    output logic [3:0]         nibble
);

    logic [1:0] hdr;
    logic [3:0] chk;
    logic       check_ok;

    always_comb begin
        hdr      = window[9:8];
        nibble   = window[7:4];
        chk      = window[3:0];
        check_ok = (chk == ~nibble);
        is_data  = (hdr == HDR_DATA);
        is_idle  = (hdr == HDR_IDLE) && (nibble == IDLE_NIBBLE);
        good     = check_ok && (is_data || is_idle);
    end

endmodule

// File: rtl/serdesphy_rx_deframer.sv
// ---------------------------------------------------------------------------
// serdesphy_rx_deframer
//
// RX frame alignment for the PHY, in the 240 MHz recovered-clock domain.
// The block searches the serial bit stream for 10-bit frame boundaries
// (HUNT). It confirms a boundary over LOCK_CNT good frames (VERIFY). While
// LOCKED it delivers data nibbles and idle strobes, and it counts bad frames.
//
// Parameters:
//   LOCK_CNT  consecutive good frames needed to lock (2..15)
//   LOSS_CNT  consecutive bad frames in LOCKED that drop alignment (1..15)
//
// Ports:
//   clk_240m_rx      in  1  RX clock from the CDR
//   rst_n_240m_rx    in  1  asynchronous active-low reset
//   rx_en            in  1  0 = synchronous clear, outputs held at reset values
//   rx_align_rst     in  1  synchronous restart of the hunt
//   rx_serial_data   in  1  serial bit, frame MSB first
//   rx_serial_valid  in  1  bit qualifier
//   rx_serial_error  in  1  deserializer error on the current bit
//   rx_word          out 4  last delivered data nibble (held)
//   rx_word_valid    out 1  one-cycle strobe for rx_word
//   rx_idle          out 1  one-cycle strobe for a good idle frame in LOCKED
//   rx_aligned       out 1  high while LOCKED
//   align_lost       out 1  one-cycle pulse when bad frames drop alignment
//   frame_err_cnt    out 8  bad frames seen in LOCKED, saturating at 255
//   rx_state         out 2  HUNT=0, VERIFY=1, LOCKED=2
// ---------------------------------------------------------------------------
module serdesphy_rx_deframer
    import serdesphy_pcs_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
)
(
    input  logic       clk_240m_rx,
    input  logic       rst_n_240m_rx,
    input  logic       rx_en,
    input  logic       rx_align_rst,
    input  logic       rx_serial_data,
    input  logic       rx_serial_valid,
    input  logic       rx_serial_error,
    output logic [3:0] rx_word,
    output logic       rx_word_valid,
    output logic       rx_idle,
    output logic       rx_aligned,
    output logic       align_lost,
    output logic [7:0] frame_err_cnt,
    output logic [1:0] rx_state
);

    localparam logic [3:0] LOCK_TGT  = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT  = 4'(LOSS_CNT);
    localparam logic [3:0] FILL_FULL = 4'd10;
    localparam logic [3:0] LAST_BIT  = 4'd9;

    rx_state_e          state_q, state_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [3:0]         fill_q, fill_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic [3:0]         bad_cnt_q, bad_cnt_d;
    logic               err_q, err_d;

    logic [3:0]         rx_word_q, rx_word_d;
    logic               rx_word_valid_q, rx_word_valid_d;
    logic               rx_idle_q, rx_idle_d;
    logic               rx_aligned_q, rx_aligned_d;
    logic               align_lost_q, align_lost_d;
    logic [7:0]         frame_err_cnt_q, frame_err_cnt_d;

    logic [FRAME_W-1:0] window;
    logic               win_good;
    logic               win_is_data;
    logic               win_is_idle;
    logic [3:0]         win_nibble;
    logic               frame_end;
    logic               frame_good;
    logic               locked_eval;

    // The window includes the bit arriving this cycle, so a frame is judged
    // on the same edge that samples its last bit.
    assign window = {sr_q[8:0], rx_serial_data};

    serdesphy_frame_check u_frame_check (
        .window  (window),
        .good    (win_good),
        .is_data (win_is_data),
        .is_idle (win_is_idle),
        .nibble  (win_nibble)
    );

    // err_q accumulates the errors of bits 9..1 of the current frame. The
    // last bit's error comes in directly.
    assign frame_end   = (bit_cnt_q == LAST_BIT);
    assign frame_good  = win_good && !err_q && !rx_serial_error;
    assign locked_eval = rx_serial_valid && (state_q == ST_LOCKED) && frame_end;

    always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
        if (!rst_n_240m_rx) begin
            state_q         <= ST_HUNT;
            sr_q            <= '0;
            fill_q          <= '0;
            bit_cnt_q       <= '0;
            good_cnt_q      <= '0;
            bad_cnt_q       <= '0;
            err_q           <= 1'b0;
            rx_word_q       <= '0;
            rx_word_valid_q <= 1'b0;
            rx_idle_q       <= 1'b0;
            rx_aligned_q    <= 1'b0;
            align_lost_q    <= 1'b0;
            frame_err_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            sr_q            <= sr_d;
            fill_q          <= fill_d;
            bit_cnt_q       <= bit_cnt_d;
            good_cnt_q      <= good_cnt_d;
            bad_cnt_q       <= bad_cnt_d;
            err_q           <= err_d;
            rx_word_q       <= rx_word_d;
            rx_word_valid_q <= rx_word_valid_d;
            rx_idle_q       <= rx_idle_d;
            rx_aligned_q    <= rx_aligned_d;
            align_lost_q    <= align_lost_d;
            frame_err_cnt_q <= frame_err_cnt_d;
        end
    end

    // Next-state and alignment counters.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        fill_d     = fill_q;
        bit_cnt_d  = bit_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_d      = err_q;

        if (!rx_en) begin
            state_d    = ST_HUNT;
            sr_d       = '0;
            fill_d     = '0;
            bit_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            err_d      = 1'b0;
        end else if (rx_align_rst) begin
            // A serial bit in this cycle is dropped on purpose. sr keeps its
            // stale contents, but fill = 0 ensures that no stale bit reaches
            // a tested window.
            state_d    = ST_HUNT;
            fill_d     = '0;
            bit_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            err_d      = 1'b0;
        end else if (rx_serial_valid) begin
            sr_d = window;
            unique case (state_q)
                ST_HUNT: begin
                    // An errored bit must fall out of the window before
                    // the hunt can test windows again.
                    if (rx_serial_error) begin
                        fill_d = '0;
                    end else if ((fill_q >= LAST_BIT) && win_good) begin
                        state_d    = ST_VERIFY;
                        good_cnt_d = 4'd1;
                        bit_cnt_d  = '0;
                        err_d      = 1'b0;
                        fill_d     = '0;
                    end else if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 4'd1;
                    end
                end
                ST_VERIFY: begin
                    if (frame_end) begin
                        bit_cnt_d = '0;
                        err_d     = 1'b0;
                        if (frame_good) begin
                            if ((good_cnt_q + 4'd1) == LOCK_TGT) begin
                                state_d   = ST_LOCKED;
                                bad_cnt_d = '0;
                            end else begin
                                good_cnt_d = good_cnt_q + 4'd1;
                            end
                        end else begin
                            // The window is already full, so the hunt can
                            // slide from the next bit on.
                            state_d    = ST_HUNT;
                            fill_d     = FILL_FULL;
                            good_cnt_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        err_d     = err_q | rx_serial_error;
                    end
                end
                ST_LOCKED: begin
                    if (frame_end) begin
                        bit_cnt_d = '0;
                        err_d     = 1'b0;
                        if (frame_good) begin
                            bad_cnt_d = '0;
                        end else if ((bad_cnt_q + 4'd1) == LOSS_TGT) begin
                            state_d    = ST_HUNT;
                            fill_d     = FILL_FULL;
                            bad_cnt_d  = '0;
                            good_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 4'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        err_d     = err_q | rx_serial_error;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // Registered outputs. Only a frame judged while already LOCKED is
    // delivered, so the frame that completes lock produces no strobe.
    always_comb begin
        rx_word_d       = rx_word_q;
        rx_word_valid_d = 1'b0;
        rx_idle_d       = 1'b0;
        align_lost_d    = 1'b0;
        frame_err_cnt_d = frame_err_cnt_q;
        rx_aligned_d    = (state_d == ST_LOCKED);

        if (!rx_en) begin
            rx_word_d       = '0;
            frame_err_cnt_d = '0;
        end else if (!rx_align_rst && locked_eval) begin
            if (frame_good) begin
                if (win_is_data) begin
                    rx_word_d       = win_nibble;
                    rx_word_valid_d = 1'b1;
                end else if (win_is_idle) begin
                    rx_idle_d = 1'b1;
                end
            end else begin
                if (frame_err_cnt_q != 8'hFF) begin
                    frame_err_cnt_d = frame_err_cnt_q + 8'd1;
                end
                if ((bad_cnt_q + 4'd1) == LOSS_TGT) begin
                    align_lost_d = 1'b1;
                end
            end
        end
    end

    assign rx_word       = rx_word_q;
    assign rx_word_valid = rx_word_valid_q;
    assign rx_idle       = rx_idle_q;
    assign rx_aligned    = rx_aligned_q;
    assign align_lost    = align_lost_q;
    assign frame_err_cnt = frame_err_cnt_q;
    assign rx_state      = state_q;

endmodule

// File: tb/tb_serdesphy_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_serdesphy_rx_deframer
//
// Directed bench for the RX deframer with the default LOCK_CNT=4 and
// LOSS_CNT=3. Frames are sent as hand-written 10-bit constants, MSB first.
// Outputs are sampled 1 time unit after the clock edge that takes each bit,
// so a strobe raised by a frame's last bit is visible right after that frame.
// ---------------------------------------------------------------------------
module tb_serdesphy_rx_deframer;

    localparam logic [9:0] IDLE_FRAME = 10'b01_0101_1010;
    localparam logic [9:0] D3_FRAME   = 10'b10_0011_1100;
    localparam logic [9:0] DA_FRAME   = 10'b10_1010_0101;
    localparam logic [9:0] D6_FRAME   = 10'b10_0110_1001;
    localparam logic [9:0] D9_FRAME   = 10'b10_1001_0110;
    localparam logic [9:0] BAD_FRAME  = 10'b10_0011_0000;

    logic       clk = 1'b0;
    logic       rstN;
    logic       rxEn;
    logic       alignRst;
    logic       serData;
    logic       serValid;
    logic       serError;
    logic [3:0] rxWord;
    logic       rxWordValid;
    logic       rxIdle;
    logic       rxAligned;
    logic       alignLost;
    logic [7:0] frameErrCnt;
    logic [1:0] rxState;

    int         totalChecks = 0;
    int         badChecks   = 0;
    bit         useGaps     = 1'b0;

    logic [3:0] wordLog[$];
    int         idleCount = 0;
    int         lostCount = 0;

    always #2 clk = ~clk;

    serdesphy_rx_deframer dut (
        .clk_240m_rx     (clk),
        .rst_n_240m_rx   (rstN),
        .rx_en           (rxEn),
        .rx_align_rst    (alignRst),
        .rx_serial_data  (serData),
        .rx_serial_valid (serValid),
        .rx_serial_error (serError),
        .rx_word         (rxWord),
        .rx_word_valid   (rxWordValid),
        .rx_idle         (rxIdle),
        .rx_aligned      (rxAligned),
        .align_lost      (alignLost),
        .frame_err_cnt   (frameErrCnt),
        .rx_state        (rxState)
    );

    // Strobe log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rxWordValid) wordLog.push_back(rxWord);
        if (rxIdle)      idleCount++;
        if (alignLost)   lostCount++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    // One accepted serial bit, optionally preceded by a random valid gap.
    task automatic applyStimulus(input logic b, input logic err, input logic rst);
        int gap;
        if (useGaps) begin
            gap = $urandom_range(0, 3);
            repeat (gap) idleCycle();
        end
        serData  = b;
        serError = err;
        alignRst = rst;
        serValid = 1'b1;
        idleCycle();
        serValid = 1'b0;
        serError = 1'b0;
        alignRst = 1'b0;
        serData  = 1'b0;
    endtask

    task automatic sendFrame(input logic [9:0] f, input int errBit);
        for (int i = 9; i >= 0; i--) applyStimulus(f[i], (i == errBit), 1'b0);
    endtask

    // Restart the hunt, add three junk bits (1,1,0) to misalign the
    // stream, then send four idle frames. No window that contains junk bits
    // passes the check.
    task automatic lockUp(input string tag);
        alignRst = 1'b1;
        idleCycle();
        alignRst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        sendFrame(IDLE_FRAME, -1);
        checkOutput({tag, "_verify"}, 32'(rxState), 32'd1);
        repeat (2) sendFrame(IDLE_FRAME, -1);
        checkOutput({tag, "_notyet"}, 32'(rxAligned), 32'd0);
        sendFrame(IDLE_FRAME, -1);
        checkOutput({tag, "_aligned"}, 32'(rxAligned), 32'd1);
        checkOutput({tag, "_state"}, 32'(rxState), 32'd2);
    endtask

    function automatic logic [31:0] logAt(input int idx);
        if (idx < wordLog.size()) return 32'(wordLog[idx]);
        return 32'hDEAD;
    endfunction

    initial begin
        int         wordBase;
        int         idleBase;
        int         lostBase;
        logic [9:0] fr;

        rstN     = 1'b0;
        rxEn     = 1'b1;
        alignRst = 1'b0;
        serData  = 1'b0;
        serValid = 1'b0;
        serError = 1'b0;

        repeat (3) idleCycle();
        checkOutput("rst_word", 32'(rxWord), 32'd0);
        checkOutput("rst_word_valid", 32'(rxWordValid), 32'd0);
        checkOutput("rst_idle", 32'(rxIdle), 32'd0);
        checkOutput("rst_aligned", 32'(rxAligned), 32'd0);
        checkOutput("rst_align_lost", 32'(alignLost), 32'd0);
        checkOutput("rst_err_cnt", 32'(frameErrCnt), 32'd0);
        checkOutput("rst_state", 32'(rxState), 32'd0);
        rstN = 1'b1;
        idleCycle();

        // Block disabled: a complete lock sequence must have no effect.
        rxEn     = 1'b0;
        wordBase = wordLog.size();
        idleBase = idleCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (5) sendFrame(IDLE_FRAME, -1);
        sendFrame(D3_FRAME, -1);
        idleCycle();
        checkOutput("dis_words", 32'(wordLog.size() - wordBase), 32'd0);
        checkOutput("dis_idles", 32'(idleCount - idleBase), 32'd0);
        checkOutput("dis_aligned", 32'(rxAligned), 32'd0);
        checkOutput("dis_state", 32'(rxState), 32'd0);
        rxEn = 1'b1;

        // Lock at an offset, then one data and one idle frame.
        wordBase = wordLog.size();
        idleBase = idleCount;
        lockUp("lock0");
        checkOutput("lock0_no_delivery", 32'(wordLog.size() - wordBase + idleCount - idleBase), 32'd0);
        sendFrame(D3_FRAME, -1);
        checkOutput("d3_valid", 32'(rxWordValid), 32'd1);
        checkOutput("d3_word", 32'(rxWord), 32'h3);
        idleCycle();
        checkOutput("d3_valid_drop", 32'(rxWordValid), 32'd0);
        checkOutput("d3_word_hold", 32'(rxWord), 32'h3);
        sendFrame(IDLE_FRAME, -1);
        checkOutput("idle_strobe", 32'(rxIdle), 32'd1);
        checkOutput("idle_no_word", 32'(rxWordValid), 32'd0);

        // The same sequence with random valid gaps.
        useGaps  = 1'b1;
        lockUp("lockgap");
        wordBase = wordLog.size();
        sendFrame(D3_FRAME, -1);
        sendFrame(DA_FRAME, -1);
        sendFrame(IDLE_FRAME, -1);
        sendFrame(D6_FRAME, -1);
        useGaps = 1'b0;
        idleCycle();
        checkOutput("gap_count", 32'(wordLog.size() - wordBase), 32'd3);
        checkOutput("gap_w0", logAt(wordBase), 32'h3);
        checkOutput("gap_w1", logAt(wordBase + 1), 32'hA);
        checkOutput("gap_w2", logAt(wordBase + 2), 32'h6);

        // Loss: two bad frames and a good one do not drop lock; three bad frames do.
        sendFrame(BAD_FRAME, -1);
        sendFrame(BAD_FRAME, -1);
        sendFrame(D3_FRAME, -1);
        checkOutput("loss_keep_aligned", 32'(rxAligned), 32'd1);
        checkOutput("loss_err2", 32'(frameErrCnt), 32'd2);
        lostBase = lostCount;
        sendFrame(BAD_FRAME, -1);
        sendFrame(BAD_FRAME, -1);
        checkOutput("loss_err4", 32'(frameErrCnt), 32'd4);
        checkOutput("loss_still_aligned", 32'(rxAligned), 32'd1);
        sendFrame(BAD_FRAME, -1);
        checkOutput("loss_pulse", 32'(alignLost), 32'd1);
        checkOutput("loss_aligned", 32'(rxAligned), 32'd0);
        checkOutput("loss_state", 32'(rxState), 32'd0);
        checkOutput("loss_err5", 32'(frameErrCnt), 32'd5);
        idleCycle();
        checkOutput("loss_pulse_drop", 32'(alignLost), 32'd0);
        checkOutput("loss_pulse_once", 32'(lostCount - lostBase), 32'd1);

        // VERIFY failure followed by a clean re-lock.
        wordBase = wordLog.size();
        alignRst = 1'b1;
        idleCycle();
        alignRst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        sendFrame(IDLE_FRAME, -1);
        sendFrame(IDLE_FRAME, -1);
        checkOutput("vfail_verify", 32'(rxState), 32'd1);
        sendFrame(BAD_FRAME, -1);
        checkOutput("vfail_hunt", 32'(rxState), 32'd0);
        checkOutput("vfail_err_unchanged", 32'(frameErrCnt), 32'd5);
        repeat (3) sendFrame(IDLE_FRAME, -1);
        checkOutput("vfail_notyet", 32'(rxAligned), 32'd0);
        sendFrame(IDLE_FRAME, -1);
        checkOutput("vfail_relock", 32'(rxAligned), 32'd1);
        checkOutput("vfail_no_words", 32'(wordLog.size() - wordBase), 32'd0);
        sendFrame(D6_FRAME, -1);
        checkOutput("vfail_d6_valid", 32'(rxWordValid), 32'd1);
        checkOutput("vfail_d6_word", 32'(rxWord), 32'h6);

        // Deserializer error on frame bit 6 while LOCKED.
        sendFrame(D9_FRAME, 6);
        checkOutput("serr_no_valid", 32'(rxWordValid), 32'd0);
        checkOutput("serr_err6", 32'(frameErrCnt), 32'd6);
        checkOutput("serr_aligned", 32'(rxAligned), 32'd1);
        sendFrame(D3_FRAME, -1);
        checkOutput("serr_next_valid", 32'(rxWordValid), 32'd1);
        checkOutput("serr_next_word", 32'(rxWord), 32'h3);

        // rx_align_rst together with a frame's last bit.
        lostBase = lostCount;
        fr       = DA_FRAME;
        for (int i = 9; i >= 1; i--) applyStimulus(fr[i], 1'b0, 1'b0);
        applyStimulus(fr[0], 1'b0, 1'b1);
        checkOutput("arst_state", 32'(rxState), 32'd0);
        checkOutput("arst_aligned", 32'(rxAligned), 32'd0);
        checkOutput("arst_no_valid", 32'(rxWordValid), 32'd0);
        checkOutput("arst_no_lost", 32'(alignLost), 32'd0);
        checkOutput("arst_err_kept", 32'(frameErrCnt), 32'd6);
        idleCycle();
        checkOutput("arst_lost_count", 32'(lostCount - lostBase), 32'd0);

        // Saturation: 300 bad frames, with a good frame after every pair
        // so that lock is kept.
        lockUp("satlock");
        for (int k = 0; k < 150; k++) begin
            sendFrame(BAD_FRAME, -1);
            sendFrame(BAD_FRAME, -1);
            sendFrame(IDLE_FRAME, -1);
            if (k == 123) checkOutput("sat_254", 32'(frameErrCnt), 32'd254);
        end
        checkOutput("sat_255", 32'(frameErrCnt), 32'd255);
        checkOutput("sat_aligned", 32'(rxAligned), 32'd1);

        // Disable: the error count and the word are cleared as well.
        rxEn = 1'b0;
        idleCycle();
        checkOutput("en_clr_err", 32'(frameErrCnt), 32'd0);
        checkOutput("en_clr_word", 32'(rxWord), 32'd0);
        checkOutput("en_clr_state", 32'(rxState), 32'd0);
        checkOutput("en_clr_aligned", 32'(rxAligned), 32'd0);
        rxEn = 1'b1;
        idleCycle();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
